// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - decode, pipelined control bundle, hazard and forwarding control
module pipeline_control_unit #(
  parameter int OPCODEWIDTH  = 4,
  parameter int REGADDRWIDTH = 4,
  parameter int ALUCTRLWIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODEWIDTH-1:0]  opcodeD,
  input  logic [REGADDRWIDTH-1:0] rs1D,
  input  logic [REGADDRWIDTH-1:0] rs2D,
  input  logic [REGADDRWIDTH-1:0] rdD,
  input  logic                    branchTakenE,
  output logic                    stallF,
  output logic                    stallD,
  output logic                    flushD,
  output logic [1:0]              forwardAE,
  output logic [1:0]              forwardBE,
  output logic [ALUCTRLWIDTH-1:0] aluControlE,
  output logic                    data2SelectorE,
  output logic                    obtainPCAsR1E,
  output logic                    writeDataEnableM,
  output logic                    outFlagM,
  output logic                    writeEnableW,
  output logic                    resultSelectorW,
  output logic [REGADDRWIDTH-1:0] rdM,
  output logic [REGADDRWIDTH-1:0] rdW
);

  // Full control bundle as produced by decode and held in E.
  typedef struct packed {
    logic       we;
    logic       d2sel;
    logic [2:0] alu;
    logic       wde;
    logic       rsel;
    logic       outf;
    logic       pcr1;
  } ctrl_e_t;

  // Fields still needed once an instruction has left E.
  typedef struct packed {
    logic we;
    logic rsel;
    logic wde;
    logic outf;
  } ctrl_m_t;

  typedef struct packed {
    logic we;
    logic rsel;
  } ctrl_w_t;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  ctrl_e_t                 ctrl_dec;

  ctrl_e_t                 ctrl_e_q, ctrl_e_d;
  logic [REGADDRWIDTH-1:0] rd_e_q, rd_e_d;
  logic [REGADDRWIDTH-1:0] rs1_e_q, rs1_e_d;
  logic [REGADDRWIDTH-1:0] rs2_e_q, rs2_e_d;
  logic                    valid_e_q, valid_e_d;

  ctrl_m_t                 ctrl_m_q, ctrl_m_d;
  logic [REGADDRWIDTH-1:0] rd_m_q, rd_m_d;
  logic                    valid_m_q, valid_m_d;

  ctrl_w_t                 ctrl_w_q, ctrl_w_d;
  logic [REGADDRWIDTH-1:0] rd_w_q, rd_w_d;
  logic                    valid_w_q, valid_w_d;

  logic                    lw_stall;
  logic                    bubble_e;

  // Decode the D-stage opcode; any nonzero bit above the low nibble means NOP.
  always_comb begin
    ctrl_dec = '0;
    if ((opcodeD >> 4) == '0) begin
      case (opcodeD[3:0])
        4'b0000: ctrl_dec.alu = 3'b000;
        4'b0001: begin
          ctrl_dec.wde = 1'b1;
          ctrl_dec.alu = 3'b110;
        end
        4'b0010: begin
          ctrl_dec.we    = 1'b1;
          ctrl_dec.d2sel = 1'b1;
          ctrl_dec.alu   = 3'b111;
        end
        4'b0011: begin
          ctrl_dec.we  = 1'b1;
          ctrl_dec.alu = 3'b110;
        end
        4'b0100: begin
          ctrl_dec.outf = 1'b1;
          ctrl_dec.alu  = 3'b110;
        end
        4'b0101: begin
          ctrl_dec.we  = 1'b1;
          ctrl_dec.alu = 3'b000;
        end
        4'b0110: begin
          ctrl_dec.we  = 1'b1;
          ctrl_dec.alu = 3'b001;
        end
        4'b0111: begin
          ctrl_dec.we   = 1'b1;
          ctrl_dec.rsel = 1'b1;
          ctrl_dec.alu  = 3'b110;
        end
        4'b1000: begin
          ctrl_dec.we  = 1'b1;
          ctrl_dec.alu = 3'b010;
        end
        4'b1001: begin
          ctrl_dec.we  = 1'b1;
          ctrl_dec.alu = 3'b101;
        end
        4'b1010: ctrl_dec.alu = 3'b001;
        default: begin
          ctrl_dec.pcr1  = 1'b1;
          ctrl_dec.d2sel = 1'b1;
          ctrl_dec.alu   = 3'b000;
        end
      endcase
    end
  end

  // Load in E whose destination matches either D source; rs2 compared even if unused.
  always_comb begin
    lw_stall = valid_e_q & ctrl_e_q.rsel & ((rd_e_q == rs1D) | (rd_e_q == rs2D));
    bubble_e = branchTakenE | lw_stall;
    flushD   = branchTakenE & ~reset;
    stallF   = lw_stall & ~branchTakenE & ~reset;
    stallD   = lw_stall & ~branchTakenE & ~reset;
  end

  // Next-state for the E/M/WB pipeline registers; E takes a bubble on flush or stall.
  always_comb begin
    ctrl_e_d  = ctrl_dec;
    rd_e_d    = rdD;
    rs1_e_d   = rs1D;
    rs2_e_d   = rs2D;
    valid_e_d = 1'b1;
    if (bubble_e) begin
      ctrl_e_d  = '0;
      rd_e_d    = '0;
      rs1_e_d   = '0;
      rs2_e_d   = '0;
      valid_e_d = 1'b0;
    end

    ctrl_m_d.we   = ctrl_e_q.we;
    ctrl_m_d.rsel = ctrl_e_q.rsel;
    ctrl_m_d.wde  = ctrl_e_q.wde;
    ctrl_m_d.outf = ctrl_e_q.outf;
    rd_m_d        = rd_e_q;
    valid_m_d     = valid_e_q;

    ctrl_w_d.we   = ctrl_m_q.we;
    ctrl_w_d.rsel = ctrl_m_q.rsel;
    rd_w_d        = rd_m_q;
    valid_w_d     = valid_m_q;
  end

  // Pipeline registers; reset discards every in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e_q  <= '0;
      rd_e_q    <= '0;
      rs1_e_q   <= '0;
      rs2_e_q   <= '0;
      valid_e_q <= 1'b0;
      ctrl_m_q  <= '0;
      rd_m_q    <= '0;
      valid_m_q <= 1'b0;
      ctrl_w_q  <= '0;
      rd_w_q    <= '0;
      valid_w_q <= 1'b0;
    end else begin
      ctrl_e_q  <= ctrl_e_d;
      rd_e_q    <= rd_e_d;
      rs1_e_q   <= rs1_e_d;
      rs2_e_q   <= rs2_e_d;
      valid_e_q <= valid_e_d;
      ctrl_m_q  <= ctrl_m_d;
      rd_m_q    <= rd_m_d;
      valid_m_q <= valid_m_d;
      ctrl_w_q  <= ctrl_w_d;
      rd_w_q    <= rd_w_d;
      valid_w_q <= valid_w_d;
    end
  end

  // E operand forwarding: M ALU result beats WB result; register 0 is ordinary.
  always_comb begin
    forwardAE = FWD_REGFILE;
    forwardBE = FWD_REGFILE;
    if (ctrl_m_q.we & valid_m_q & (rs1_e_q == rd_m_q)) begin
      forwardAE = FWD_MEM;
    end else if (ctrl_w_q.we & valid_w_q & (rs1_e_q == rd_w_q)) begin
      forwardAE = FWD_WB;
    end
    if (ctrl_m_q.we & valid_m_q & (rs2_e_q == rd_m_q)) begin
      forwardBE = FWD_MEM;
    end else if (ctrl_w_q.we & valid_w_q & (rs2_e_q == rd_w_q)) begin
      forwardBE = FWD_WB;
    end
  end

  // Per-stage control outputs straight from the stage registers.
  always_comb begin
    aluControlE      = ALUCTRLWIDTH'(ctrl_e_q.alu);
    data2SelectorE   = ctrl_e_q.d2sel;
    obtainPCAsR1E    = ctrl_e_q.pcr1;
    writeDataEnableM = ctrl_m_q.wde;
    outFlagM         = ctrl_m_q.outf;
    rdM              = rd_m_q;
    writeEnableW     = ctrl_w_q.we;
    resultSelectorW  = ctrl_w_q.rsel;
    rdW              = rd_w_q;
  end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb/tb_pipeline_control_unit.sv - self-checking bench for pipeline_control_unit
module tb_pipeline_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcodeD = '0;
  logic [3:0] rs1D = '0, rs2D = '0, rdD = '0;
  logic       branchTakenE = 1'b0;
  logic       stallF, stallD, flushD;
  logic [1:0] forwardAE, forwardBE;
  logic [2:0] aluControlE;
  logic       data2SelectorE, obtainPCAsR1E;
  logic       writeDataEnableM, outFlagM;
  logic       writeEnableW, resultSelectorW;
  logic [3:0] rdM, rdW;

  int checks = 0;
  int errors = 0;

  pipeline_control_unit #(
    .OPCODEWIDTH(4), .REGADDRWIDTH(4), .ALUCTRLWIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .opcodeD(opcodeD), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .branchTakenE(branchTakenE), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .aluControlE(aluControlE),
    .data2SelectorE(data2SelectorE), .obtainPCAsR1E(obtainPCAsR1E),
    .writeDataEnableM(writeDataEnableM), .outFlagM(outFlagM),
    .writeEnableW(writeEnableW), .resultSelectorW(resultSelectorW), .rdM(rdM), .rdW(rdW)
  );

  always #5 clk = ~clk;

  wire [26:0] all_out = {stallF, stallD, flushD, forwardAE, forwardBE, aluControlE,
                         data2SelectorE, obtainPCAsR1E, writeDataEnableM, outFlagM,
                         writeEnableW, resultSelectorW, rdM, rdW};

  // Reference model: the instruction occupying each stage.
  typedef struct packed {
    logic       v;
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } ins_t;

  ins_t me = '0, mm = '0, mw = '0;

  // Instruction table: {we, d2sel, alu[2:0], wde, rsel, out, pcR1}
  function automatic logic [8:0] dec(input logic [3:0] op);
    case (op)
      4'd0:    return {1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd1:    return {1'b0, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0};
      4'd2:    return {1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd3:    return {1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd4:    return {1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0};
      4'd5:    return {1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd6:    return {1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd7:    return {1'b1, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0};
      4'd8:    return {1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd9:    return {1'b1, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd10:   return {1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
      default: return {1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
    endcase
  endfunction

  function automatic logic writes(input ins_t i);
    logic [8:0] c;
    c = dec(i.op);
    return i.v && c[8];
  endfunction

  function automatic logic model_lw();
    return me.v && (me.op == 4'd7) && (me.rd == rs1D || me.rd == rs2D);
  endfunction

  function automatic logic [1:0] model_fwd(input logic [3:0] rs);
    if (writes(mm) && mm.rd == rs) return 2'b10;
    if (writes(mw) && mw.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Advance the model across the edge just passed, then present new D-stage inputs.
  task automatic set_in(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] r1,
                        input logic [3:0] r2, input logic br);
    @(negedge clk);
    if (reset) begin
      me = '0; mm = '0; mw = '0;
    end else begin
      logic lw;
      lw = model_lw();
      mw = mm;
      mm = me;
      if (branchTakenE || lw) me = '0;
      else me = {1'b1, opcodeD, rdD, rs1D, rs2D};
    end
    opcodeD = op; rdD = rd; rs1D = r1; rs2D = r2; branchTakenE = br;
    #1;
  endtask

  task automatic test_reset();
    set_in(4'd7, 4'd0, 4'd0, 4'd0, 1'b1);
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_alu_latency();
    set_in(4'd5, 4'd3, 4'd0, 4'd0, 1'b0);
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if ({aluControlE, data2SelectorE, obtainPCAsR1E} !== 5'b0) begin
      errors++; $display("FAIL latency_e: got %b expected 00000", {aluControlE, data2SelectorE, obtainPCAsR1E});
    end
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if ({writeEnableW, rdW} !== {1'b1, 4'd3}) begin
      errors++; $display("FAIL latency_w: got we=%b rd=%0d expected we=1 rd=3", writeEnableW, rdW);
    end
  endtask

  task automatic test_load_use();
    set_in(4'd7, 4'd5, 4'd0, 4'd0, 1'b0);
    set_in(4'd5, 4'd1, 4'd5, 4'd9, 1'b0);
    checks++;
    if ({stallF, stallD, flushD} !== 3'b110) begin
      errors++; $display("FAIL lw_stall: got %b expected 110", {stallF, stallD, flushD});
    end
    set_in(4'd5, 4'd1, 4'd5, 4'd9, 1'b0);
    checks++;
    if ({stallF, stallD, aluControlE, data2SelectorE} !== 6'b0) begin
      errors++; $display("FAIL lw_bubble: got %b expected 000000", {stallF, stallD, aluControlE, data2SelectorE});
    end
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if (forwardAE !== 2'b01) begin
      errors++; $display("FAIL lw_forward: got %b expected 01", forwardAE);
    end
  endtask

  task automatic test_forwarding();
    set_in(4'd5, 4'd2, 4'd7, 4'd7, 1'b0);
    set_in(4'd6, 4'd4, 4'd7, 4'd2, 1'b0);
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if (forwardBE !== 2'b10) begin
      errors++; $display("FAIL fwd_mem: got %b expected 10", forwardBE);
    end
    set_in(4'd5, 4'd2, 4'd7, 4'd7, 1'b0);
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    set_in(4'd6, 4'd4, 4'd7, 4'd2, 1'b0);
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if (forwardBE !== 2'b01) begin
      errors++; $display("FAIL fwd_wb: got %b expected 01", forwardBE);
    end
    set_in(4'd5, 4'd2, 4'd7, 4'd7, 1'b0);
    set_in(4'd5, 4'd2, 4'd7, 4'd7, 1'b0);
    set_in(4'd6, 4'd4, 4'd7, 4'd2, 1'b0);
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if (forwardBE !== 2'b10) begin
      errors++; $display("FAIL fwd_priority: got %b expected 10", forwardBE);
    end
  endtask

  task automatic test_branch_flush();
    set_in(4'd12, 4'd0, 4'd0, 4'd0, 1'b0);
    set_in(4'd2, 4'd1, 4'd8, 4'd8, 1'b1);
    checks++;
    if ({obtainPCAsR1E, data2SelectorE, flushD, stallD} !== 4'b1110) begin
      errors++; $display("FAIL branch_e: got %b expected 1110", {obtainPCAsR1E, data2SelectorE, flushD, stallD});
    end
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if ({aluControlE, data2SelectorE, obtainPCAsR1E, flushD} !== 6'b0) begin
      errors++; $display("FAIL branch_bubble: got %b expected 000000", {aluControlE, data2SelectorE, obtainPCAsR1E, flushD});
    end
  endtask

  task automatic test_branch_over_stall();
    set_in(4'd7, 4'd6, 4'd0, 4'd0, 1'b0);
    set_in(4'd2, 4'd1, 4'd6, 4'd9, 1'b1);
    checks++;
    if ({stallF, stallD, flushD} !== 3'b001) begin
      errors++; $display("FAIL branch_priority: got %b expected 001", {stallF, stallD, flushD});
    end
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if (aluControlE !== 3'b000) begin
      errors++; $display("FAIL branch_priority_bubble: got %b expected 000", aluControlE);
    end
  endtask

  task automatic test_store_out();
    set_in(4'd1, 4'd0, 4'd0, 4'd0, 1'b0);
    set_in(4'd4, 4'd0, 4'd0, 4'd0, 1'b0);
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if ({writeDataEnableM, outFlagM} !== 2'b10) begin
      errors++; $display("FAIL store_m: got %b expected 10", {writeDataEnableM, outFlagM});
    end
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if ({writeDataEnableM, outFlagM, writeEnableW} !== 3'b010) begin
      errors++; $display("FAIL out_m_store_w: got %b expected 010", {writeDataEnableM, outFlagM, writeEnableW});
    end
  endtask

  task automatic test_reset_midstream();
    set_in(4'd5, 4'd3, 4'd0, 4'd0, 1'b0);
    set_in(4'd2, 4'd4, 4'd3, 4'd3, 1'b0);
    set_in(4'd7, 4'd5, 4'd4, 4'd3, 1'b0);
    set_in(4'd5, 4'd1, 4'd5, 4'd4, 1'b1);
    reset = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_mid: got %h expected 0", all_out);
    end
    set_in(4'd2, 4'd1, 4'd0, 4'd0, 1'b0);
    reset = 1'b0;
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if ({aluControlE, data2SelectorE, rdM, writeEnableW} !== {3'b111, 1'b1, 4'd0, 1'b0}) begin
      errors++; $display("FAIL reset_release: got %b expected 1111_0000_0", {aluControlE, data2SelectorE, rdM, writeEnableW});
    end
  endtask

  task automatic test_random();
    logic [3:0] op = '0, rd = '0, r1 = '0, r2 = '0;
    logic       hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [8:0] ce, cm, cw;
      logic       st;
      if (!hold) begin
        op = 4'($urandom_range(0, 15));
        rd = 4'($urandom_range(0, 3));
        r1 = 4'($urandom_range(0, 3));
        r2 = 4'($urandom_range(0, 3));
      end
      set_in(op, rd, r1, r2, ($urandom_range(0, 7) == 0));
      ce = me.v ? dec(me.op) : 9'd0;
      cm = mm.v ? dec(mm.op) : 9'd0;
      cw = mw.v ? dec(mw.op) : 9'd0;
      st = model_lw() && !branchTakenE;
      hold = st;
      checks++;
      if ({stallF, stallD, flushD} !== {st, st, branchTakenE}) begin
        errors++; $display("FAIL rnd_hazard n=%0d: got %b expected %b", n, {stallF, stallD, flushD}, {st, st, branchTakenE});
      end
      checks++;
      if ({forwardAE, forwardBE} !== {model_fwd(me.rs1), model_fwd(me.rs2)}) begin
        errors++; $display("FAIL rnd_forward n=%0d: got %b expected %b", n, {forwardAE, forwardBE}, {model_fwd(me.rs1), model_fwd(me.rs2)});
      end
      checks++;
      if ({aluControlE, data2SelectorE, obtainPCAsR1E} !== {ce[6:4], ce[7], ce[0]}) begin
        errors++; $display("FAIL rnd_e n=%0d: got %b expected %b", n, {aluControlE, data2SelectorE, obtainPCAsR1E}, {ce[6:4], ce[7], ce[0]});
      end
      checks++;
      if ({writeDataEnableM, outFlagM, rdM} !== {cm[3], cm[1], mm.rd}) begin
        errors++; $display("FAIL rnd_m n=%0d: got %b expected %b", n, {writeDataEnableM, outFlagM, rdM}, {cm[3], cm[1], mm.rd});
      end
      checks++;
      if ({writeEnableW, resultSelectorW, rdW} !== {cw[8], cw[2], mw.rd}) begin
        errors++; $display("FAIL rnd_w n=%0d: got %b expected %b", n, {writeEnableW, resultSelectorW, rdW}, {cw[8], cw[2], mw.rd});
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_latency();
    test_load_use();
    test_forwarding();
    test_branch_flush();
    test_branch_over_stall();
    test_store_out();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
